// File: rtl/dds_freq_meter_if.sv
// Handshake and result bundle for the DDS frequency/duty meter.
// The master side issues start and reads the results; the slave side is the meter.
interface dds_freq_meter_if #(
   parameter int CNT_W = 32
);
   logic             start;
   logic             busy;
   logic             meas_valid;
   logic             timeout;
   logic [CNT_W-1:0] period_sum;
   logic [CNT_W-1:0] high_sum;

   modport master (
      output start,
      input  busy, meas_valid, timeout, period_sum, high_sum
   );

   modport slave (
      input  start,
      output busy, meas_valid, timeout, period_sum, high_sum
   );
endinterface

// File: rtl/dds_freq_meter.sv
// Frequency/duty meter for the DDS square wave. Synchronises sig_in, waits for
// a rising edge, then accumulates period and high time over 2^AVG_LOG2 input
// periods, giving up after TIMEOUT_CYC busy cycles.
module dds_freq_meter #(
   parameter int          CNT_W       = 32,
   parameter int          AVG_LOG2    = 3,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sig_in,
   dds_freq_meter_if.slave bus
);

   // One extra bit so AVG_LOG2 = 0 still yields a legal vector.
   localparam int               EC_W       = AVG_LOG2 + 1;
   localparam logic [EC_W-1:0]  LAST_EDGE  = EC_W'((1 << AVG_LOG2) - 1);
   // Timer value seen on the final allowed busy cycle.
   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // sync_reg[1] is the synced level (s2), sync_reg[2] its one-cycle delay (s3).
   logic [2:0]       sync_reg;
   logic             s2;
   logic             rise;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] timer_reg, timer_next;
   logic [EC_W-1:0]  edge_cnt_reg, edge_cnt_next;
   logic [CNT_W-1:0] period_cnt_reg, period_cnt_next;
   logic [CNT_W-1:0] high_cnt_reg, high_cnt_next;
   logic [CNT_W-1:0] period_sum_reg, period_sum_next;
   logic [CNT_W-1:0] high_sum_reg, high_sum_next;
   logic             timeout_reg, timeout_next;
   logic             timer_hit;

   // Two-flop synchroniser plus a delay stage for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= 3'b000;
      end else begin
         sync_reg <= {sync_reg[1:0], sig_in};
      end
   end

   assign s2        = sync_reg[1];
   assign rise      = sync_reg[1] & ~sync_reg[2];
   assign timer_hit = (timer_reg == TIMER_LAST);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         timer_reg      <= '0;
         edge_cnt_reg   <= '0;
         period_cnt_reg <= '0;
         high_cnt_reg   <= '0;
         period_sum_reg <= '0;
         high_sum_reg   <= '0;
         timeout_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         edge_cnt_reg   <= edge_cnt_next;
         period_cnt_reg <= period_cnt_next;
         high_cnt_reg   <= high_cnt_next;
         period_sum_reg <= period_sum_next;
         high_sum_reg   <= high_sum_next;
         timeout_reg    <= timeout_next;
      end
   end

   // Next-state and counter update; completion is tested before timeout so a
   // final rise on the last allowed cycle still produces a result.
   always_comb begin
      state_next      = state_reg;
      timer_next      = timer_reg;
      edge_cnt_next   = edge_cnt_reg;
      period_cnt_next = period_cnt_reg;
      high_cnt_next   = high_cnt_reg;
      period_sum_next = period_sum_reg;
      high_sum_next   = high_sum_reg;
      timeout_next    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next      = ARM;
               timer_next      = '0;
               edge_cnt_next   = '0;
               period_cnt_next = '0;
               high_cnt_next   = '0;
            end
         end

         ARM: begin
            timer_next = timer_reg + 1'b1;
            if (timer_hit) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
            end else if (rise) begin
               state_next = MEASURE;
            end
         end

         MEASURE: begin
            timer_next      = timer_reg + 1'b1;
            period_cnt_next = period_cnt_reg + 1'b1;
            high_cnt_next   = high_cnt_reg + CNT_W'(s2);
            if (rise) begin
               edge_cnt_next = edge_cnt_reg + 1'b1;
            end
            if (rise && (edge_cnt_reg == LAST_EDGE)) begin
               state_next      = DONE;
               period_sum_next = period_cnt_reg + 1'b1;
               high_sum_next   = high_cnt_reg + CNT_W'(s2);
            end else if (timer_hit) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.busy       = (state_reg == ARM) || (state_reg == MEASURE);
   assign bus.meas_valid = (state_reg == DONE);
   assign bus.timeout    = timeout_reg;
   assign bus.period_sum = period_sum_reg;
   assign bus.high_sum   = high_sum_reg;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Bench for dds_freq_meter: an event-level reference model predicts, at each
// accepted start, the whole outcome of the measurement from the driven wave,
// and a per-cycle compare process checks every output against it.
module tb_dds_freq_meter;

   localparam int CNT_W    = 32;
   localparam int AVG_LOG2 = 3;
   localparam int N        = 1 << AVG_LOG2;
   localparam int T        = 4096;
   localparam int MAXC     = 60000;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic sig_in = 1'b0;

   dds_freq_meter_if #(.CNT_W(CNT_W)) bus_if ();

   dds_freq_meter #(
      .CNT_W      (CNT_W),
      .AVG_LOG2   (AVG_LOG2),
      .TIMEOUT_CYC(T)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sig_in(sig_in),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = -1;              // index of the most recent rising edge
   bit hist [0:MAXC-1];          // value of sig_in driven during each cycle

   // Wave description: period 0 means a constant level.
   int w_per   = 0;
   int w_high  = 0;
   int w_ph    = 0;
   bit w_const = 1'b0;

   function automatic bit wave_fn(int c);
      if (w_per == 0) return w_const;
      return (((c + w_per - w_ph) % w_per) < w_high);
   endfunction

   // Level of sig_in during cycle x: recorded history for the past, the
   // current wave description for the future.
   function automatic bit lvl(int x);
      if (x < 0) return 1'b0;
      if (x <= cyc && x < MAXC) return hist[x];
      return wave_fn(x);
   endfunction

   // Driver: one new sig_in value per cycle, just after the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         sig_in = wave_fn(cyc);
         if (cyc < MAXC) hist[cyc] = sig_in;
      end
   end

   // ---------------- reference model ----------------
   int busy_lo   = -1;
   int busy_hi   = -2;
   int mv_cyc    = -1;
   int to_cyc    = -1;
   int free_from = 0;
   logic [CNT_W-1:0] cur_p  = '0;
   logic [CNT_W-1:0] cur_h  = '0;
   logic [CNT_W-1:0] pend_p = '0;
   logic [CNT_W-1:0] pend_h = '0;

   // Start sampled during idle cycle c: the meter sees the level two cycles
   // late, a rise is a synced 0->1, the window runs from the first rise to
   // the Nth rise after it, and everything must finish by cycle c+T.
   function automatic void plan(int c);
      int t0 = -1;
      int tn = -1;
      int rises = 0;
      int hs = 0;
      bit r;
      for (int t = c + 1; t <= c + T; t++) begin
         r = lvl(t - 2) & ~lvl(t - 3);
         if (t0 < 0) begin
            if (r) t0 = t;
         end else begin
            hs = hs + int'(lvl(t - 2));
            if (r) begin
               rises = rises + 1;
               if (rises == N) begin
                  tn = t;
                  break;
               end
            end
         end
      end
      busy_lo = c + 1;
      if (tn >= 0) begin
         busy_hi   = tn;
         mv_cyc    = tn + 1;
         to_cyc    = -1;
         pend_p    = CNT_W'(tn - t0);
         pend_h    = CNT_W'(hs);
         free_from = tn + 2;
      end else begin
         busy_hi   = c + T;
         mv_cyc    = -1;
         to_cyc    = c + T + 1;
         free_from = c + T + 1;
      end
   endfunction

   // Per-cycle compare of all outputs against the model.
   always @(negedge clk) begin : cmp
      logic                 e_busy, e_mv, e_to;
      logic [2*CNT_W+2:0]   exp_v, act_v;
      if (!rst_n) begin
         busy_lo   = -1;
         busy_hi   = -2;
         mv_cyc    = -1;
         to_cyc    = -1;
         cur_p     = '0;
         cur_h     = '0;
         free_from = cyc + 1;
      end else if (cyc == mv_cyc) begin
         cur_p = pend_p;
         cur_h = pend_h;
      end
      e_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      e_mv   = (cyc == mv_cyc);
      e_to   = (cyc == to_cyc);
      exp_v  = {e_busy, e_mv, e_to, cur_p, cur_h};
      act_v  = {bus_if.busy, bus_if.meas_valid, bus_if.timeout, bus_if.period_sum, bus_if.high_sum};
      checks = checks + 1;
      if (act_v !== exp_v) begin
         errors = errors + 1;
         $display("FAIL cycle %0d outputs: got busy=%b mv=%b to=%b psum=%0d hsum=%0d, want busy=%b mv=%b to=%b psum=%0d hsum=%0d",
                  cyc, bus_if.busy, bus_if.meas_valid, bus_if.timeout, bus_if.period_sum, bus_if.high_sum,
                  e_busy, e_mv, e_to, cur_p, cur_h);
      end
      if (rst_n && bus_if.start && cyc >= free_from) plan(cyc);
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wave(input int p, input int h, input int ph, input bit k);
      w_per   = p;
      w_high  = h;
      w_ph    = ph;
      w_const = k;
   endtask

   task automatic pulse_start(output int sc);
      sc = cyc;
      bus_if.start = 1'b1;
      step();
      bus_if.start = 1'b0;
   endtask

   task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Returns 1 on meas_valid, 2 on timeout, 0 if neither came within limit.
   task automatic wait_done(input int limit, output int kind, output int at);
      kind = 0;
      at   = -1;
      for (int n = 0; n < limit; n++) begin
         step();
         if (bus_if.meas_valid) begin
            kind = 1;
            at   = cyc;
            return;
         end
         if (bus_if.timeout) begin
            kind = 2;
            at   = cyc;
            return;
         end
      end
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_done: no meas_valid or timeout within %0d cycles", limit);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scenarios ----------------
   initial begin
      int kind, at, sc, cnt, m, c, p, h, ph;
      bus_if.start = 1'b0;
      set_wave(0, 0, 0, 1'b0);
      rst_n = 1'b0;
      repeat (3) step();
      expect_eq("reset busy", 64'(bus_if.busy), 64'(0));
      expect_eq("reset meas_valid", 64'(bus_if.meas_valid), 64'(0));
      expect_eq("reset timeout", 64'(bus_if.timeout), 64'(0));
      expect_eq("reset period_sum", 64'(bus_if.period_sum), 64'(0));
      expect_eq("reset high_sum", 64'(bus_if.high_sum), 64'(0));
      rst_n = 1'b1;
      repeat (5) step();

      // Period 10, high 5.
      set_wave(10, 5, 3, 1'b0);
      repeat (8) step();
      pulse_start(sc);
      wait_done(T + 100, kind, at);
      expect_eq("s1 kind", 64'(kind), 64'(1));
      expect_eq("s1 period_sum", 64'(bus_if.period_sum), 64'(80));
      expect_eq("s1 high_sum", 64'(bus_if.high_sum), 64'(40));
      step();
      expect_eq("s1 busy after", 64'(bus_if.busy), 64'(0));

      // Period 7, high 2 at three start phases.
      for (int i = 0; i < 3; i++) begin
         set_wave(7, 2, 2 * i, 1'b0);
         repeat (6 + i + $urandom_range(0, 6)) step();
         pulse_start(sc);
         wait_done(T + 100, kind, at);
         expect_eq("s2 kind", 64'(kind), 64'(1));
         expect_eq("s2 period_sum", 64'(bus_if.period_sum), 64'(56));
         expect_eq("s2 high_sum", 64'(bus_if.high_sum), 64'(16));
      end

      // Start pulses during MEASURE are ignored; then reset mid-MEASURE.
      set_wave(10, 5, 1, 1'b0);
      repeat (6) step();
      pulse_start(sc);
      repeat (30) step();
      for (int i = 0; i < 3; i++) begin
         pulse_start(sc);
         repeat (6) step();
      end
      wait_done(T + 100, kind, at);
      expect_eq("s4 kind", 64'(kind), 64'(1));
      expect_eq("s4 period_sum", 64'(bus_if.period_sum), 64'(80));
      expect_eq("s4 high_sum", 64'(bus_if.high_sum), 64'(40));
      cnt = 0;
      for (int i = 0; i < 150; i++) begin
         step();
         if (bus_if.meas_valid) cnt = cnt + 1;
      end
      expect_eq("s4 extra meas_valid", 64'(cnt), 64'(0));
      pulse_start(sc);
      repeat (40) step();
      rst_n = 1'b0;
      #1;
      expect_eq("s4 rst busy", 64'(bus_if.busy), 64'(0));
      expect_eq("s4 rst meas_valid", 64'(bus_if.meas_valid), 64'(0));
      expect_eq("s4 rst timeout", 64'(bus_if.timeout), 64'(0));
      expect_eq("s4 rst period_sum", 64'(bus_if.period_sum), 64'(0));
      expect_eq("s4 rst high_sum", 64'(bus_if.high_sum), 64'(0));
      step();
      step();
      rst_n = 1'b1;
      repeat (6) step();
      pulse_start(sc);
      wait_done(T + 100, kind, at);
      expect_eq("s4 post-reset period_sum", 64'(bus_if.period_sum), 64'(80));
      expect_eq("s4 post-reset high_sum", 64'(bus_if.high_sum), 64'(40));

      // Input stuck low: timeout TIMEOUT_CYC+1 cycles after the start sample.
      set_wave(0, 0, 0, 1'b0);
      repeat (8) step();
      pulse_start(sc);
      wait_done(T + 100, kind, at);
      expect_eq("s3 kind", 64'(kind), 64'(2));
      expect_eq("s3 timeout latency", 64'(at - sc), 64'(T + 1));
      expect_eq("s3 period_sum kept", 64'(bus_if.period_sum), 64'(80));
      expect_eq("s3 high_sum kept", 64'(bus_if.high_sum), 64'(40));

      // Start held high: back-to-back measurements 90 cycles apart.
      set_wave(10, 5, 4, 1'b0);
      repeat (8) step();
      bus_if.start = 1'b1;
      c = -1;
      for (int i = 0; i < 3; i++) begin
         wait_done(T + 100, kind, at);
         expect_eq("s5 kind", 64'(kind), 64'(1));
         expect_eq("s5 period_sum", 64'(bus_if.period_sum), 64'(80));
         expect_eq("s5 high_sum", 64'(bus_if.high_sum), 64'(40));
         if (c >= 0) expect_eq("s5 spacing", 64'(at - c), 64'(90));
         c = at;
      end
      bus_if.start = 1'b0;
      repeat (5) step();

      // 8th rise on the last allowed busy cycle: completion wins.
      set_wave(511, 200, 0, 1'b0);
      m = (cyc + 20) / 511 + 1;
      c = 511 * m - 6;
      while (cyc < c) step();
      pulse_start(sc);
      wait_done(T + 100, kind, at);
      expect_eq("s6 kind", 64'(kind), 64'(1));
      expect_eq("s6 latency", 64'(at - sc), 64'(T + 1));
      expect_eq("s6 period_sum", 64'(bus_if.period_sum), 64'(4088));
      expect_eq("s6 high_sum", 64'(bus_if.high_sum), 64'(1600));

      // One cycle later the 8th rise misses the deadline: timeout, sums kept.
      m = (cyc + 20) / 511 + 1;
      c = 511 * m - 7;
      while (cyc < c) step();
      pulse_start(sc);
      wait_done(T + 100, kind, at);
      expect_eq("s6b kind", 64'(kind), 64'(2));
      expect_eq("s6b latency", 64'(at - sc), 64'(T + 1));
      expect_eq("s6b period_sum kept", 64'(bus_if.period_sum), 64'(4088));
      expect_eq("s6b high_sum kept", 64'(bus_if.high_sum), 64'(1600));

      // Random ideal waves: sums are exactly N*P and N*H.
      for (int i = 0; i < 10; i++) begin
         p  = int'($urandom_range(3, 60));
         h  = int'($urandom_range(1, p - 1));
         ph = int'($urandom_range(0, p - 1));
         set_wave(p, h, ph, 1'b0);
         repeat (6 + $urandom_range(0, 14)) step();
         pulse_start(sc);
         wait_done(T + 100, kind, at);
         expect_eq("rand kind", 64'(kind), 64'(1));
         expect_eq("rand period_sum", 64'(bus_if.period_sum), 64'(N * p));
         expect_eq("rand high_sum", 64'(bus_if.high_sum), 64'(N * h));
      end

      repeat (5) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
